// File: rtl/fifo_stream_reader.sv
// Read-side engine for the synchronous FIFO: issues credit-limited reads and
// presents the returned words as a framed valid/ready stream via a 3-entry buffer.

module fifo_stream_reader_chk (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] buf_count,
    input  logic       inflight,
    input  logic       pop
);

    // A captured word must always find a free slot in the buffer
    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !((buf_count == 2'd3) && inflight && !pop));

endmodule

module fifo_stream_reader #(
    parameter int DATA_WIDTH = 8,
    parameter int BURST_LEN  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_rd_data,
    output logic                  fifo_rd_en,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_last,
    output logic [1:0]            buf_count,
    output logic                  busy
);

    // BURST_LEN is legal over 1..256, so the final beat index always fits in 8 bits
    localparam logic [7:0] LAST_BEAT = 8'(BURST_LEN - 1);

    function automatic logic [1:0] ptr_inc(input logic [1:0] ptr);
        logic [1:0] nxt;
        case (ptr)
            2'd0:    nxt = 2'd1;
            2'd1:    nxt = 2'd2;
            default: nxt = 2'd0;
        endcase
        return nxt;
    endfunction

    logic [DATA_WIDTH-1:0] buf_mem_r [0:2];
    logic [1:0]            wr_ptr_r;
    logic [1:0]            rd_ptr_r;
    logic [1:0]            count_r;
    logic                  inflight_r;
    logic [7:0]            beat_cnt_r;

    logic                  rd_en_s;
    logic                  credit_ok_s;
    logic                  push_s;
    logic                  pop_s;
    logic [1:0]            count_next_s;
    logic [7:0]            beat_next_s;
    logic [DATA_WIDTH-1:0] m_data_s;

    // Credit check uses registered occupancy only, so m_ready never reaches fifo_rd_en
    always_comb begin
        credit_ok_s = (({1'b0, count_r} + {2'b00, inflight_r}) < 3'd3);
        if (en && !rst && !fifo_empty && credit_ok_s) begin
            rd_en_s = 1'b1;
        end else begin
            rd_en_s = 1'b0;
        end
    end

    assign push_s = inflight_r;
    assign pop_s  = (count_r != 2'd0) && m_ready;

    // Occupancy update; a simultaneous capture and pop leaves the count unchanged
    always_comb begin
        case ({push_s, pop_s})
            2'b10:   count_next_s = count_r + 2'd1;
            2'b01:   count_next_s = count_r - 2'd1;
            default: count_next_s = count_r;
        endcase
    end

    // Beat counter advances only on handshakes and wraps at the burst boundary
    always_comb begin
        if (pop_s) begin
            if (beat_cnt_r == LAST_BEAT) begin
                beat_next_s = 8'd0;
            end else begin
                beat_next_s = beat_cnt_r + 8'd1;
            end
        end else begin
            beat_next_s = beat_cnt_r;
        end
    end

    // Buffer storage, pointers, in-flight flag and beat counter
    always_ff @(posedge clk) begin
        if (rst) begin
            buf_mem_r[0] <= {DATA_WIDTH{1'b0}};
            buf_mem_r[1] <= {DATA_WIDTH{1'b0}};
            buf_mem_r[2] <= {DATA_WIDTH{1'b0}};
            wr_ptr_r     <= 2'd0;
            rd_ptr_r     <= 2'd0;
            count_r      <= 2'd0;
            inflight_r   <= 1'b0;
            beat_cnt_r   <= 8'd0;
        end else begin
            if (push_s) begin
                buf_mem_r[wr_ptr_r] <= fifo_rd_data;
                wr_ptr_r            <= ptr_inc(wr_ptr_r);
            end
            if (pop_s) begin
                rd_ptr_r <= ptr_inc(rd_ptr_r);
            end
            count_r    <= count_next_s;
            inflight_r <= rd_en_s;
            beat_cnt_r <= beat_next_s;
        end
    end

    // Head word is forced to zero while the buffer is empty
    always_comb begin
        if (count_r != 2'd0) begin
            m_data_s = buf_mem_r[rd_ptr_r];
        end else begin
            m_data_s = {DATA_WIDTH{1'b0}};
        end
    end

    assign fifo_rd_en = rd_en_s;
    assign m_valid    = (count_r != 2'd0);
    assign m_data     = m_data_s;
    assign m_last     = (count_r != 2'd0) && (beat_cnt_r == LAST_BEAT);
    assign buf_count  = count_r;
    assign busy       = (count_r != 2'd0) || inflight_r;

    fifo_stream_reader_chk u_chk (
        .clk       (clk),
        .rst       (rst),
        .buf_count (count_r),
        .inflight  (inflight_r),
        .pop       (pop_s)
    );

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Bench for fifo_stream_reader: behavioural FIFO model, data/last scoreboard,
// a small table of read-issue vectors and directed multi-cycle sequences.

module tb_fifo_stream_reader;

    localparam int DW = 8;
    localparam int BL = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          en = 1'b0;
    logic          fifo_empty;
    logic [DW-1:0] fifo_rd_data = '0;
    logic          fifo_rd_en;
    logic          m_valid;
    logic          m_ready = 1'b0;
    logic [DW-1:0] m_data;
    logic          m_last;
    logic [1:0]    buf_count;
    logic          busy;

    always #5 clk = ~clk;

    fifo_stream_reader #(.DATA_WIDTH(DW), .BURST_LEN(BL)) dut (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .fifo_empty   (fifo_empty),
        .fifo_rd_data (fifo_rd_data),
        .fifo_rd_en   (fifo_rd_en),
        .m_valid      (m_valid),
        .m_ready      (m_ready),
        .m_data       (m_data),
        .m_last       (m_last),
        .buf_count    (buf_count),
        .busy         (busy)
    );

    // FIFO model with one-cycle read latency
    logic [DW-1:0] fmem [0:255];
    int            wr_idx = 0;
    int            rd_idx = 0;
    assign fifo_empty = (rd_idx == wr_idx);

    always @(posedge clk) begin
        if (fifo_rd_en) begin
            fifo_rd_data <= fmem[rd_idx[7:0]];
            rd_idx       <= rd_idx + 1;
        end
    end

    typedef struct {
        logic rst_v;
        logic en_v;
        logic has_data;
        logic exp_rd_en;
    } vec_t;

    vec_t          vecs [5];
    logic [DW-1:0] exp_q [$];
    int            n_checks = 0;
    int            n_fail = 0;
    int            beat_idx = 0;
    int            cyc = 0;
    int            hs_cnt, first_hs, last_hs, max_buf, credit_viol, stab_viol;
    logic          rd_seen, hold_prev, prev_last;
    logic [DW-1:0] prev_data;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic clear_stats();
        hs_cnt = 0; first_hs = -1; last_hs = -1; max_buf = 0;
        credit_viol = 0; stab_viol = 0; rd_seen = 1'b0; hold_prev = 1'b0;
    endtask

    task automatic push_word(input logic [DW-1:0] d);
        fmem[wr_idx[7:0]] = d;
        exp_q.push_back(d);
        wr_idx++;
    endtask

    // Sample at the falling edge, then advance to just after the next rising edge
    task automatic tick();
        logic [DW-1:0] e;
        @(negedge clk);
        if (fifo_rd_en) rd_seen = 1'b1;
        if (buf_count == 2'd3 && fifo_rd_en) credit_viol++;
        if (int'(buf_count) > max_buf) max_buf = int'(buf_count);
        if (hold_prev && (!m_valid || m_data !== prev_data || m_last !== prev_last)) stab_viol++;
        hold_prev = m_valid && !m_ready;
        prev_data = m_data;
        prev_last = m_last;
        if (m_valid && m_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_beat", 32'(m_data), 32'hFFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                check("beat_data", 32'(m_data), 32'(e));
                check("beat_last", 32'(m_last), 32'(beat_idx == BL - 1));
                beat_idx = (beat_idx == BL - 1) ? 0 : beat_idx + 1;
                hs_cnt++;
                if (first_hs < 0) first_hs = cyc;
                last_hs = cyc;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        rst = 1'b1; en = 1'b0; m_ready = 1'b0;
        tick();
        tick();
        wr_idx = rd_idx;
        exp_q.delete();
        beat_idx = 0;
        rst = 1'b0;
        clear_stats();
    endtask

    task automatic drain(input int max_cyc, input string name);
        int c = 0;
        while (!(exp_q.size() == 0 && !busy) && c < max_cyc) begin
            tick();
            c++;
        end
        check(name, 32'(exp_q.size() == 0 && !busy), 32'd1);
    endtask

    initial begin
        int t;
        vecs[0] = '{rst_v: 1'b0, en_v: 1'b0, has_data: 1'b0, exp_rd_en: 1'b0};
        vecs[1] = '{rst_v: 1'b0, en_v: 1'b1, has_data: 1'b0, exp_rd_en: 1'b0};
        vecs[2] = '{rst_v: 1'b0, en_v: 1'b0, has_data: 1'b1, exp_rd_en: 1'b0};
        vecs[3] = '{rst_v: 1'b0, en_v: 1'b1, has_data: 1'b1, exp_rd_en: 1'b1};
        vecs[4] = '{rst_v: 1'b1, en_v: 1'b1, has_data: 1'b1, exp_rd_en: 1'b0};
        clear_stats();
        @(posedge clk);
        #1;

        // Reset then idle
        do_reset();
        check("rst_rd_en", 32'(fifo_rd_en), 32'd0);
        check("rst_m_valid", 32'(m_valid), 32'd0);
        check("rst_m_data", 32'(m_data), 32'd0);
        check("rst_m_last", 32'(m_last), 32'd0);
        check("rst_buf_count", 32'(buf_count), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        for (int i = 0; i < 5; i++) tick();
        check("idle_no_read", 32'(rd_seen), 32'd0);

        // Read-issue table, applied between edges and undone before the next one
        for (int i = 0; i < 5; i++) begin
            rst = vecs[i].rst_v;
            en  = vecs[i].en_v;
            if (vecs[i].has_data) begin
                fmem[wr_idx[7:0]] = 8'hEE;
                wr_idx++;
            end
            #1;
            check($sformatf("vec%0d_rd_en", i), 32'(fifo_rd_en), 32'(vecs[i].exp_rd_en));
            check($sformatf("vec%0d_m_valid", i), 32'(m_valid), 32'd0);
            wr_idx = rd_idx; en = 1'b0; rst = 1'b0;
            #1;
        end
        tick();
        check("vec_idle_busy", 32'(busy), 32'd0);

        // Single word latency
        do_reset();
        push_word(8'hA5); en = 1'b1; m_ready = 1'b1;
        #1;
        check("single_rd_en_N", 32'(fifo_rd_en), 32'd1);
        tick();
        check("single_rd_en_N1", 32'(fifo_rd_en), 32'd0);
        check("single_busy_N1", 32'(busy), 32'd1);
        check("single_valid_N1", 32'(m_valid), 32'd0);
        tick();
        check("single_valid_N2", 32'(m_valid), 32'd1);
        check("single_data_N2", 32'(m_data), 32'hA5);
        check("single_last_N2", 32'(m_last), 32'd0);
        check("single_count_N2", 32'(buf_count), 32'd1);
        tick();
        check("single_busy_N3", 32'(busy), 32'd0);
        check("single_beats", 32'(hs_cnt), 32'd1);

        // Streaming with no back-pressure
        do_reset();
        for (int i = 0; i < 16; i++) push_word(8'(i));
        en = 1'b1; m_ready = 1'b1;
        drain(60, "stream_done");
        check("stream_beats", 32'(hs_cnt), 32'd16);
        check("stream_no_bubbles", 32'(last_hs - first_hs), 32'd15);
        check("stream_max_buf", 32'(max_buf), 32'd1);

        // Back-pressure window
        do_reset();
        for (int i = 0; i < 16; i++) push_word(8'(8'h40 + i));
        en = 1'b1;
        t = 0;
        while (!(exp_q.size() == 0 && !busy) && t < 80) begin
            m_ready = !(t >= 5 && t <= 9);
            tick();
            t++;
        end
        check("bp_done", 32'(exp_q.size() == 0 && !busy), 32'd1);
        check("bp_beats", 32'(hs_cnt), 32'd16);
        check("bp_max_buf", 32'(max_buf), 32'd3);
        check("bp_credit", 32'(credit_viol), 32'd0);
        check("bp_stable", 32'(stab_viol), 32'd0);

        // Enable gating after two reads
        do_reset();
        for (int i = 0; i < 6; i++) push_word(8'(8'h10 + i));
        m_ready = 1'b1; en = 1'b1;
        tick();
        tick();
        en = 1'b0;
        rd_seen = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        check("gate_no_read", 32'(rd_seen), 32'd0);
        check("gate_beats", 32'(hs_cnt), 32'd2);
        check("gate_valid", 32'(m_valid), 32'd0);
        check("gate_busy", 32'(busy), 32'd0);
        check("gate_left", 32'(exp_q.size()), 32'd4);
        en = 1'b1;
        drain(30, "gate_resume_done");
        check("gate_total", 32'(hs_cnt), 32'd6);

        // Reset with two buffered words and one in flight
        do_reset();
        for (int i = 0; i < 8; i++) push_word(8'(8'h20 + i));
        en = 1'b1; m_ready = 1'b1;
        t = 0;
        while (hs_cnt < 1 && t < 10) begin tick(); t++; end
        m_ready = 1'b0;
        t = 0;
        while (!(buf_count == 2'd2 && !fifo_rd_en && !fifo_empty) && t < 10) begin tick(); t++; end
        check("mid_setup", 32'(buf_count == 2'd2 && !fifo_rd_en && !fifo_empty), 32'd1);
        rst = 1'b1;
        exp_q.delete();
        beat_idx = 0;
        tick();
        check("mid_count", 32'(buf_count), 32'd0);
        check("mid_valid", 32'(m_valid), 32'd0);
        check("mid_busy", 32'(busy), 32'd0);
        check("mid_last", 32'(m_last), 32'd0);
        clear_stats();
        tick();
        wr_idx = rd_idx;
        rst = 1'b0;
        for (int i = 0; i < 4; i++) push_word(8'(8'h30 + i));
        m_ready = 1'b1;
        drain(30, "mid_after_done");
        check("mid_after_beats", 32'(hs_cnt), 32'd4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fifo_stream_reader.md
Name: fifo_stream_reader

Overview:
- Read-side engine for the team's synchronous FIFO.
- Drives the FIFO read port (rd_en/empty/rd_data, one-cycle read latency) and presents the data as a valid/ready stream with burst framing (m_last every BURST_LEN beats).
- A 3-entry output buffer keeps full throughput (1 beat/cycle) under back-pressure, with no combinational path from m_ready to fifo_rd_en.

Parameters:
- DATA_WIDTH, 8, width of FIFO words and m_data.
- BURST_LEN, 4, beats per burst; m_last marks beat BURST_LEN-1. Legal range 1..256.

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst  input  1  synchronous reset, active-high.
- en  input  1  fetch enable; when low no new FIFO reads are issued, but buffered data still drains.
- fifo_empty  input  1  FIFO empty flag.
- fifo_rd_data  input  DATA_WIDTH  FIFO read data; valid in the cycle after a read is issued.
- fifo_rd_en  output  1  FIFO read strobe.
- m_valid  output  1  stream data valid.
- m_ready  input  1  stream sink ready.
- m_data  output  DATA_WIDTH  stream data.
- m_last  output  1  final beat of the current burst.
- buf_count  output  2  output buffer occupancy, 0..3.
- busy  output  1  high when buf_count != 0 or a read is in flight.

Behaviour:
- Reset (synchronous, rst=1 at a clk edge): buffer emptied, inflight=0, beat_cnt=0, read/write pointers=0. All outputs then read 0: fifo_rd_en=0, m_valid=0, m_data=0, m_last=0, buf_count=0, busy=0. A reset mid-operation discards buffered and in-flight words; the system resets the FIFO in the same window.
- Read issue (combinational from registered state only): fifo_rd_en = en & !rst & !fifo_empty & (buf_count + inflight < 3).
- inflight register: inflight <= fifo_rd_en each cycle.
- Capture: when inflight=1, fifo_rd_data is written into the buffer at the end of that cycle. It is captured in exactly that cycle and never sampled otherwise.
- Output: m_valid = (buf_count != 0). m_data is the oldest buffered word; order is strictly FIFO-preserving.
- Pop: handshake = m_valid & m_ready; it removes the oldest entry.
- Simultaneous capture and pop: buf_count is unchanged and both pointers advance.
- Overflow: cannot occur by construction; the credit check guarantees a slot for every in-flight word. A verification assertion flags buf_count==3 & inflight & no pop.
- Stability: while m_valid & !m_ready, m_data and m_last hold stable and m_valid stays high.
- Latency: fifo_rd_en high in cycle N -> word is at the buffer head and m_valid=1 in cycle N+2, provided the buffer was empty.
- Throughput: with m_ready held high and the FIFO non-empty, steady state is buf_count=1, inflight=1, and one beat per cycle.
- Burst framing: beat_cnt (8 bits) increments on each handshake and wraps to 0 after BURST_LEN-1. m_last = m_valid & (beat_cnt == BURST_LEN-1). For BURST_LEN=1, m_last is high on every valid beat.
- beat_cnt ignores en and fifo_empty; a partially sent burst resumes its count when data returns.
- en deasserted: no reads from the next cycle; the in-flight word is still captured; buffered words drain normally.
- Pointer arithmetic: buffer pointers are mod 3 (0,1,2 then wrap to 0). buf_count is 2 bits, saturating by construction at 3.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, FIFO empty -> all outputs 0, fifo_rd_en never asserts.
- Single word: FIFO holds 0xA5, en=1, m_ready=1 -> fifo_rd_en for 1 cycle (N); m_valid=1, m_data=0xA5 at N+2; m_last=0 (beat 0 of 4); busy returns to 0 at N+3.
- Streaming: FIFO preloaded 0x00..0x0F, m_ready=1 -> 16 consecutive beats 0x00..0x0F with no bubbles after the first; m_last on 0x03, 0x07, 0x0B, 0x0F.
- Back-pressure: same preload, m_ready low cycles 5..9 -> buf_count peaks at 3, fifo_rd_en low while the buffer plus in-flight equals 3, m_data frozen, no words lost or duplicated, order preserved.
- Enable gating: en dropped after 2 reads issued -> both words are delivered, then m_valid=0. Re-raising en resumes at the next word, and beat_cnt continues (third beat is index 2, m_last on the fourth).
- Reset mid-burst: rst asserted with buf_count=2, inflight=1 -> next cycle buf_count=0, m_valid=0, beat_cnt=0. The first beat after reset has m_last=0 even if the prior burst was partial.
